// File: rtl/carry_chain_pipe.sv
// Pipelined P/G ripple carry chain: WIDTH bits resolved SEG bits per stage,
// valid/ready at both ends, with optional carry chaining between beats.
module carry_chain_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] G,
    input  logic             CIN,
    input  logic             cin_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             COUT
);

    localparam int unsigned STAGES = WIDTH / SEG;
    // Every stage except the last blocks a chained beat until its predecessor lands.
    localparam logic [STAGES-1:0] UPMASK = {STAGES{1'b1}} >> 1;

    logic              advance;
    logic              chain_block;
    logic              accept;
    logic              cin0;
    logic              carry_q;
    logic [STAGES-1:0] vbits;

    assign advance     = !out_valid | out_ready;
    assign chain_block = cin_sel & (|(vbits & UPMASK));
    assign in_ready    = advance & !chain_block;
    assign accept      = in_valid & in_ready;
    assign cin0        = cin_sel ? carry_q : CIN;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // Stage k holds resolved sum bits [SW-1:0] and raw P/G still to be resolved.
        localparam int unsigned RW = WIDTH - k * SEG;
        localparam int unsigned SW = (k + 1) * SEG;

        logic          v_q;
        logic          v_n;
        logic          c_q;
        logic          c_src;
        logic          seg_c;
        logic [RW-1:0] p_src;
        logic [RW-1:0] g_src;
        logic [SEG-1:0] seg_s;
        logic [SW-1:0] s_q;
        logic [SW-1:0] s_n;

        if (k == 0) begin : g_in
            assign v_n   = accept;
            assign p_src = P;
            assign g_src = G;
            assign c_src = cin0;
            assign s_n   = seg_s;
        end else begin : g_in
            assign v_n   = stg[k-1].v_q;
            assign p_src = stg[k-1].g_pg.p_q;
            assign g_src = stg[k-1].g_pg.g_q;
            assign c_src = stg[k-1].c_q;
            assign s_n   = {seg_s, stg[k-1].s_q};
        end

        // Ripple the lowest unresolved segment.
        always_comb begin : ripple
            seg_c = c_src;
            seg_s = '0;
            for (int b = 0; b < int'(SEG); b++) begin
                seg_s[b] = p_src[b] ^ seg_c;
                seg_c    = p_src[b] ? seg_c : g_src[b];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_n;
                c_q <= seg_c;
                s_q <= s_n;
            end
        end

        if (k < STAGES - 1) begin : g_pg
            logic [RW-SEG-1:0] p_q;
            logic [RW-SEG-1:0] g_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_q <= '0;
                    g_q <= '0;
                end else if (advance) begin
                    p_q <= p_src[RW-1:SEG];
                    g_q <= g_src[RW-1:SEG];
                end
            end
        end

        assign vbits[k] = v_q;
    end

    // Carry of the most recent beat to reach the last stage, for chained adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (advance && stg[STAGES-1].v_n) begin
            carry_q <= stg[STAGES-1].seg_c;
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign S         = stg[STAGES-1].s_q;
    assign COUT      = stg[STAGES-1].c_q;

endmodule

// File: tb/tb_carry_chain_pipe.sv
// Scoreboard bench for carry_chain_pipe: arithmetic reference model, decoupled monitor.
module tb_carry_chain_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned W1 = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] p = '0;
    logic [W-1:0] g = '0;
    logic         cin = 1'b0;
    logic         cin_sel = 1'b0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;

    logic         in_valid1 = 1'b0;
    logic         in_ready1;
    logic [W-1:0] p1 = '0;
    logic [W-1:0] g1 = '0;
    logic         cin1 = 1'b0;
    logic         cin_sel1 = 1'b0;
    logic         out_valid1;
    logic         out_ready1 = 1'b1;
    logic [W-1:0] s1;
    logic         cout1;

    logic rand_or = 1'b0;
    logic rnd_or = 1'b1;
    logic or_force = 1'b1;
    assign out_ready = rand_or ? rnd_or : or_force;

    int        tests = 0;
    int        fails = 0;
    int        cyc = 0;
    logic      model_carry = 1'b0;
    logic [W:0] sb[$];
    int        pop_cyc[$];

    carry_chain_pipe #(.WIDTH(W), .SEG(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .P(p), .G(g), .CIN(cin), .cin_sel(cin_sel), .out_valid(out_valid),
        .out_ready(out_ready), .S(s), .COUT(cout)
    );

    carry_chain_pipe #(.WIDTH(W), .SEG(W)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .P(p1), .G(g1), .CIN(cin1), .cin_sel(cin_sel1), .out_valid(out_valid1),
        .out_ready(out_ready1), .S(s1), .COUT(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_or = ($urandom_range(0, 3) != 0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: retire one expected beat per output handshake.
    always begin
        @(negedge clk);
        #3;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got S=%h COUT=%b, required no output", s, cout);
            end else begin
                chk("result", 64'({cout, s}), 64'(sb.pop_front()));
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Present a beat until accepted; expectation is the arithmetic sum a+b+cin
    // with a=P|G, b=G (valid because stimulus keeps P&G=0), or a given constant.
    task automatic send(input logic [W-1:0] pp, input logic [W-1:0] gg, input logic ci,
                        input logic sel, input bit has_exp, input logic [W:0] exp_v,
                        output int waits);
        logic [W:0] sum;
        logic       cie;
        @(negedge clk);
        p = pp; g = gg; cin = ci; cin_sel = sel; in_valid = 1'b1;
        waits = 0;
        #1;
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
            #1;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", waits);
            in_valid = 1'b0;
        end else begin
            cie = sel ? model_carry : ci;
            sum = W1'(pp | gg) + W1'(gg) + W1'(cie);
            if (has_exp) sum = exp_v;
            model_carry = sum[W];
            sb.push_back(sum);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic rand_beat(input logic sel, output int waits);
        logic [W-1:0] rp;
        logic [W-1:0] rg;
        rp = $urandom;
        rg = $urandom;
        rg = rg & ~rp;
        send(rp, rg, 1'($urandom_range(0, 1)), sel, 1'b0, '0, waits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        logic [W:0] held;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_s_cout", 64'({cout, s}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // a=FFFFFFFF + b=1 and its 4-edge latency
        send(32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 1'b1, {1'b1, 32'h0}, w);
        idle();
        #1;
        chk("lat_e0", 64'(out_valid), 64'(0));
        repeat (2) @(negedge clk);
        #1;
        chk("lat_e2", 64'(out_valid), 64'(0));
        @(negedge clk);
        #1;
        chk("lat_e3", 64'(out_valid), 64'(1));
        drain();

        // full-width propagate path
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1, {1'b1, 32'h0}, w);
        idle();
        drain();

        // back-to-back throughput
        pop_cyc.delete();
        repeat (4) rand_beat(1'b0, w);
        idle();
        drain();
        chk("b2b_count", 64'(pop_cyc.size()), 64'(4));
        if (pop_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                chk("b2b_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'(1));

        // output stall with a full pipeline
        or_force = 1'b0;
        repeat (4) rand_beat(1'b0, w);
        idle();
        #1;
        held = {cout, s};
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_hold", 64'({cout, s}), 64'(held));
            @(negedge clk);
            #1;
        end
        or_force = 1'b1;
        drain();

        // chained multi-word add
        send(32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 1'b1, {1'b1, 32'h0}, w);
        send(32'h0, 32'h0, 1'b0, 1'b1, 1'b1, {1'b0, 32'h1}, w);
        chk("chain_wait", 64'(w), 64'(3));
        idle();
        drain();

        // randomized traffic with back-pressure and chaining
        rand_or = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rand_beat(1'($urandom_range(0, 3) == 0), w);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        rand_or = 1'b0;
        drain();

        // single-stage build: chained beat accepted on the very next cycle
        @(negedge clk);
        p1 = 32'hFFFF_FFFE; g1 = 32'h1; cin1 = 1'b0; cin_sel1 = 1'b0; in_valid1 = 1'b1;
        #1;
        chk("seg_w_ready0", 64'(in_ready1), 64'(1));
        @(negedge clk);
        p1 = 32'h0; g1 = 32'h0; cin_sel1 = 1'b1;
        #1;
        chk("seg_w_ready1", 64'(in_ready1), 64'(1));
        chk("seg_w_out0", 64'({out_valid1, cout1, s1}), 64'({2'b11, 32'h0}));
        @(negedge clk);
        in_valid1 = 1'b0;
        #1;
        chk("seg_w_out1", 64'({out_valid1, cout1, s1}), 64'({2'b10, 32'h1}));
        @(negedge clk);
        #1;
        chk("seg_w_empty", 64'(out_valid1), 64'(0));

        // reset with beats in flight
        or_force = 1'b0;
        repeat (2) rand_beat(1'b0, w);
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out", 64'({out_valid, cout, s}), 64'(0));
        sb.delete();
        model_carry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        or_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", 64'(out_valid), 64'(0));
        end
        send(32'h1, 32'h0, 1'b0, 1'b1, 1'b1, {1'b0, 32'h1}, w);
        idle();
        drain();
        repeat (3) @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
